// File: rtl/core_pkg.sv
// Shared RV32 core definitions: load/store func3 codes, the data-memory FSM
// encoding and the default ack timeout, plus small legality helpers.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // Stores only know B/H/W; loads additionally have the unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'd1:    return ~lo[0];
      2'd2:    return (lo == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: byte enables and store replication for the
// outgoing request, lane select and sign/zero extension for returning loads.
module dmem_lane_align
  import core_pkg::*;
(
  input  logic [1:0]  req_addr_lo,
  input  logic [1:0]  req_size,
  input  logic [31:0] st_data,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_func3,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = st_data;
    case ({1'b0, req_size})
      F3_B: begin
        req_be    = 4'b0001 << req_addr_lo;
        req_wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        req_be    = 4'b0011 << {req_addr_lo[1], 1'b0};
        req_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0 before extending.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_data    = ld_rdata;
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_BU:   ld_data = {24'd0, ld_shifted[7:0]};
      F3_HU:   ld_data = {16'd0, ld_shifted[15:0]};
      F3_W:    ld_data = ld_rdata;
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack FSM with pipeline stall,
// ack timeout, misalignment and access-fault reporting.
module dmem_access_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic [31:0] me_alu_o,
  input  logic [31:0] me_regs_data2,
  input  logic [2:0]  me_func3_code,
  input  logic [1:0]  me_priv_mode,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic [1:0]  dmem_priv,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  input  logic [31:0] dmem_rdata,
  output logic        wb_load_valid,
  output logic [31:0] wb_load_data,
  output logic        exc_misalign,
  output logic        exc_access_fault,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  // Handshake: dmem_req and all request fields stay constant from REQ entry
  // until the cycle dmem_ack is seen (or the timeout fires); dmem_ack is a
  // single-cycle completion and is ignored outside REQ.
  dmem_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, fault_q, fault_d, wbv_q, wbv_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wbd_q, wbd_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  priv_q, priv_d, lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;
  logic        access, legal, aligned, start;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ld;

  dmem_lane_align u_lane (
    .req_addr_lo (me_alu_o[1:0]),
    .req_size    (me_func3_code[1:0]),
    .st_data     (me_regs_data2),
    .req_be      (lane_be),
    .req_wdata   (lane_wdata),
    .ld_addr_lo  (lo_q),
    .ld_func3    (f3_q),
    .ld_rdata    (dmem_rdata),
    .ld_data     (lane_ld)
  );

  always_comb begin
    access  = me_mem_read | me_mem_write;
    legal   = f3_legal(me_mem_write, me_func3_code);
    aligned = addr_aligned(me_func3_code, me_alu_o[1:0]);
    start   = access & legal & aligned;

    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    priv_d  = priv_q;
    lo_d    = lo_q;
    f3_d    = f3_q;
    wbd_d   = wbd_q;
    wbv_d   = 1'b0;
    fault_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = me_mem_write;
          addr_d  = {me_alu_o[31:2], 2'b00};
          be_d    = lane_be;
          wdata_d = lane_wdata;
          priv_d  = me_priv_mode;
          lo_d    = me_alu_o[1:0];
          f3_d    = me_func3_code;
        end
      end
      ST_REQ: begin
        if (dmem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          fault_d = dmem_err;
          wbv_d   = ~dmem_err & ~we_q;
          if (~dmem_err & ~we_q) wbd_d = lane_ld;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      priv_q  <= '0;
      lo_q    <= '0;
      f3_q    <= '0;
      wbd_q   <= '0;
      wbv_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      priv_q  <= priv_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
      wbd_q   <= wbd_d;
      wbv_q   <= wbv_d;
      fault_q <= fault_d;
    end
  end

  // DONE deliberately drops the stall so the pipeline advances exactly once.
  assign mem_stall        = rstn & (((state_q == ST_IDLE) & start) | (state_q == ST_REQ));
  assign exc_misalign     = rstn & (state_q == ST_IDLE) & access & legal & ~aligned;
  assign exc_access_fault = rstn & (((state_q == ST_IDLE) & access & ~legal) | fault_q);
  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_be          = be_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_priv        = priv_q;
  assign wb_load_valid    = wbv_q;
  assign wb_load_data     = wbd_q;
  assign dbg_state        = state_q;

endmodule
